// File: rtl/voice_pkg.sv
// voice_pkg
//   Shared constants for the voice allocator slice.
//   NOTE_W / DUR_W : default note-code and duration widths
//   REST_NOTE      : note code meaning "no sound"; never allocated a voice
//   MAX_VOICES     : largest voice bank the selector is sized for
package voice_pkg;

  localparam int NOTE_W     = 6;
  localparam int DUR_W      = 6;
  localparam int REST_NOTE  = 0;
  localparam int MAX_VOICES = 8;

endpackage

// File: rtl/voice_select.sv
// voice_select
//   Combinational voice chooser. Picks the voice with the smallest
//   effective remaining duration, lowest index on ties. A free voice has
//   eff == 0, which is the global minimum, so this also yields the
//   lowest-index free voice whenever one exists.
// Ports:
//   eff    in  NUM_VOICES*DUR_W  packed per-voice effective remaining beats
//   choice out NUM_VOICES        one-hot selected voice
//   steal  out 1                 selected voice is still occupied
module voice_select #(
  parameter int NUM_VOICES = 3,
  parameter int DUR_W      = 6
) (
  input  logic [NUM_VOICES*DUR_W-1:0] eff,
  output logic [NUM_VOICES-1:0]       choice,
  output logic                        steal
);
  import voice_pkg::*;

  localparam int IDX_W = $clog2(MAX_VOICES);

  logic [IDX_W-1:0] best_idx;
  logic [DUR_W-1:0] best_val;

  // Strict less-than keeps the earlier (lower-index) voice on ties.
  always_comb begin
    best_idx = '0;
    best_val = eff[DUR_W-1:0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (eff[v*DUR_W +: DUR_W] < best_val) begin
        best_val = eff[v*DUR_W +: DUR_W];
        best_idx = IDX_W'(v);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_onehot
      assign choice[gi] = (best_idx == IDX_W'(gi));
    end
  endgenerate

  // Minimum still non-zero means every voice is occupied.
  assign steal = (best_val != '0);

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator
//   Dynamic voice scheduler between the note-event stream and a bank of
//   note_player voices. Each voice's remaining duration is counted down on
//   beats; new notes go to a free voice or preempt the one nearest to done.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   play                  playback enable (freezes counters, drops requests)
//   flush                 synchronous clear of all occupancy
//   beat                  one-cycle beat tick
//   req_valid/note/duration  incoming note event
//   load_note             one-hot load strobe to the chosen voice
//   note_out/duration_out shared data bus for the strobed voice (held)
//   voice_busy            registered per-voice occupancy
//   steal                 strobe went to an occupied voice
//   dropped               previous cycle's request was discarded
module voice_allocator #(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  flush,
  input  logic                  beat,
  input  logic                  req_valid,
  input  logic [NOTE_W-1:0]     req_note,
  input  logic [DUR_W-1:0]      req_duration,
  output logic [NUM_VOICES-1:0] load_note,
  output logic [NOTE_W-1:0]     note_out,
  output logic [DUR_W-1:0]      duration_out,
  output logic [NUM_VOICES-1:0] voice_busy,
  output logic                  steal,
  output logic                  dropped
);
  import voice_pkg::*;

  logic [DUR_W-1:0]            remaining_reg  [NUM_VOICES];
  logic [DUR_W-1:0]            remaining_next [NUM_VOICES];
  logic [NUM_VOICES*DUR_W-1:0] eff_flat;
  logic [NUM_VOICES-1:0]       busy_next;
  logic [NUM_VOICES-1:0]       sel_choice;
  logic                        sel_steal;
  logic                        beat_en;
  logic                        accept;

  // Beats only count while playing; flush wins over everything else.
  assign beat_en = beat && play;
  assign accept  = req_valid && play && !flush
                   && (req_note != NOTE_W'(REST_NOTE))
                   && (req_duration != '0);

  // Effective occupancy already includes this cycle's beat, so a voice that
  // finishes on this beat is treated as free for a same-cycle request.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_eff
      assign eff_flat[gi*DUR_W +: DUR_W] =
        (beat_en && (remaining_reg[gi] != '0)) ? (remaining_reg[gi] - DUR_W'(1))
                                               : remaining_reg[gi];
    end
  endgenerate

  voice_select #(
    .NUM_VOICES (NUM_VOICES),
    .DUR_W      (DUR_W)
  ) u_select (
    .eff    (eff_flat),
    .choice (sel_choice),
    .steal  (sel_steal)
  );

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      remaining_next[v] = eff_flat[v*DUR_W +: DUR_W];
      if (flush) begin
        remaining_next[v] = '0;
      end else if (accept && sel_choice[v]) begin
        remaining_next[v] = req_duration;
      end
    end
  end

  // Busy flags are registered from the next-state value so they line up
  // with remaining_reg in the same cycle.
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_busy
      assign busy_next[gi] = (remaining_next[gi] != '0);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        remaining_reg[v] <= '0;
      end
      load_note    <= '0;
      note_out     <= '0;
      duration_out <= '0;
      voice_busy   <= '0;
      steal        <= 1'b0;
      dropped      <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        remaining_reg[v] <= remaining_next[v];
      end
      voice_busy <= busy_next;
      load_note  <= accept ? sel_choice : '0;
      steal      <= accept && sel_steal;
      dropped    <= req_valid && !accept;
      if (accept) begin
        note_out     <= req_note;
        duration_out <= req_duration;
      end
    end
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Dynamic voice scheduler between the song reader's note-event stream and the NUM_VOICES note_player instances.
- Accepts one note event per cycle. Routes it to a free voice, or steals the voice closest to finishing.
- Tracks each voice's remaining duration by counting beats, so the bank is shared without fixed channel assignment.
- Output strobes drive the note_player load_new_note inputs directly.

Parameters:
- NUM_VOICES, 3: number of note_player voices managed (2..8).
- NOTE_W, 6: note code width.
- DUR_W, 6: duration width, in beats.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- play  in  1  playback enable; when low, beats are not counted and requests are dropped
- flush  in  1  synchronous clear of all voice occupancy (song change / reset_player)
- beat  in  1  one-cycle beat tick
- req_valid  in  1  note event present this cycle
- req_note  in  NOTE_W  note code; 0 = rest
- req_duration  in  DUR_W  duration in beats
- load_note  out  NUM_VOICES  one-hot load strobe to the selected voice
- note_out  out  NOTE_W  note for the strobed voice (shared bus)
- duration_out  out  DUR_W  duration for the strobed voice (shared bus)
- voice_busy  out  NUM_VOICES  bit v set while remaining[v] != 0
- steal  out  1  pulses together with load_note when an occupied voice was preempted
- dropped  out  1  pulses one cycle after a request that was discarded

Behaviour:
- Reset (async): remaining[*]=0; load_note=0; note_out=0; duration_out=0; steal=0; dropped=0; voice_busy=0.
- State per voice: remaining[v], DUR_W bits, unsigned.
- Beat update: on beat && play, every remaining[v] > 0 decrements by 1. Saturates at 0, never wraps.
- Effective occupancy: eff[v] = remaining[v] - (beat && play && remaining[v] != 0). This is the value after this cycle's beat.
- A request is accepted iff req_valid && play && !flush && req_note != 0 && req_duration != 0. Otherwise, if req_valid is high, dropped pulses on the next cycle.
- Selection for an accepted request:
  - Lowest-index v with eff[v] == 0.
  - If none, v = argmin eff[v], ties to the lowest index, and steal = 1.
- Commit at the clock edge:
  - remaining[v] <= req_duration. This overrides the beat decrement for that voice.
  - load_note <= one-hot(v), note_out <= req_note, duration_out <= req_duration.
- Latency: one cycle from request to strobe. load_note, steal and dropped are single-cycle pulses. note_out and duration_out hold their last values.
- Throughput: one request per cycle; back-to-back requests see the previous commit.
  - Example: 3 requests on consecutive cycles with all voices idle go to voices 0, 1, 2.
- flush:
  - Next edge: remaining[*] <= 0 and outputs go to idle.
  - Any same-cycle request is dropped.
  - flush takes priority over beat and over a request.
- play low: remaining values freeze, load_note=0, and requests are dropped.
- voice_busy is registered and derived from remaining. It matches note_player occupancy because both count the same beat.
- Reset asserted mid-operation clears all state immediately. No strobe is emitted after reset releases until a new accepted request.

Decomposition:
- Shared package `voice_pkg`: NOTE_W, DUR_W, REST_NOTE=0, MAX_VOICES=8.
- One combinational sub-module, `voice_select`: inputs eff vector; outputs one-hot choice and a steal flag. Free-first priority encoder plus min-finder with a lowest-index tie break.
- Top module holds the remaining registers, the request qualifier and the output registers.

Test Plan:
- After reset, with play=1: requests (note 20, dur 4), (22, 2), (25, 3) on consecutive cycles -> load_note = 001, 010, 100 on cycles +1..+3; voice_busy = 111; steal = 0.
- All voices busy with remaining {4, 2, 3}: request (30, 5) -> load_note = 010, steal = 1, remaining = {4, 5, 3}.
- remaining {1, 2, 3}: beat and request (40, 6) in the same cycle -> voice 0 is freed by the beat and chosen, steal = 0; next cycle remaining = {6, 1, 2}.
- Request with note 0, or with dur 0, or with play=0 -> load_note stays 0; dropped pulses one cycle later; remaining is unchanged.
- play=0 for 10 beats with remaining {3, 0, 2} -> remaining stays frozen; play=1 then 2 beats -> {1, 0, 0}, voice_busy = 001.
- flush asserted together with a request while busy -> next cycle remaining all 0, voice_busy = 000, no load strobe, dropped = 1. Async reset asserted mid-countdown -> all outputs 0 immediately.
